// File: rtl/vc_req_sel_rr.sv
// Virtual-channel request selector for one router input port.
//
// Picks one requesting VC round-robin and presents its one-hot output-port
// request to the switch allocator as a registered, stable request. The
// request is held until it is granted, squashed (the VC drops its valid), or
// times out after WAIT_LIMIT ungranted cycles. After a grant or timeout the
// next requester is loaded back-to-back with no bubble cycle.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   vc_valid   per-VC head-flit valid
//   req_in     per-VC request vectors, VC v in [v*NUM_PORT +: NUM_PORT]
//   grant      allocator accepted the presented request this cycle
//   req_valid  req_out/sel_vc carry a live request
//   req_out    registered request vector of the selected VC
//   sel_vc     index of the selected VC
//   timeout    one-cycle pulse when a held request is rotated out by timeout

module vc_req_sel_rr #(
  parameter int unsigned NUM_VC         = 5,
  parameter int unsigned NUM_PORT       = 5,
  parameter int unsigned VC_INDEX_WIDTH = 3,
  parameter int unsigned WAIT_LIMIT     = 15,
  parameter int unsigned WAIT_W         = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_VC-1:0]           vc_valid,
  input  logic [NUM_VC*NUM_PORT-1:0]  req_in,
  input  logic                        grant,
  output logic                        req_valid,
  output logic [NUM_PORT-1:0]         req_out,
  output logic [VC_INDEX_WIDTH-1:0]   sel_vc,
  output logic                        timeout
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [VC_INDEX_WIDTH-1:0] LastVc   = VC_INDEX_WIDTH'(NUM_VC - 1);
  localparam logic [VC_INDEX_WIDTH:0]   NumVcExt = (VC_INDEX_WIDTH + 1)'(NUM_VC);
  localparam logic [WAIT_W-1:0]         WaitLim  = WAIT_W'(WAIT_LIMIT);
  localparam bit                        TimeoutEn = (WAIT_LIMIT != 0);

  state_e                      state_q, state_d;
  logic [VC_INDEX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]           wait_q, wait_d;
  logic                        req_valid_q, req_valid_d;
  logic [NUM_PORT-1:0]         req_out_q, req_out_d;
  logic [VC_INDEX_WIDTH-1:0]   sel_vc_q, sel_vc_d;
  logic                        timeout_q, timeout_d;

  logic [VC_INDEX_WIDTH-1:0]   sel_next;
  logic [VC_INDEX_WIDTH-1:0]   search_start;
  logic [2*NUM_VC-1:0]         vld_rot;
  logic                        found;
  logic [VC_INDEX_WIDTH-1:0]   found_off;
  logic [VC_INDEX_WIDTH:0]     found_sum;
  logic [VC_INDEX_WIDTH-1:0]   found_idx;
  logic [NUM_PORT-1:0]         found_req;
  logic                        held_valid;
  logic                        load, release_req;

  // Explicit compare so non-power-of-two VC counts wrap correctly.
  assign sel_next = (sel_vc_q == LastVc) ? '0 : sel_vc_q + VC_INDEX_WIDTH'(1);

  // Idle searches from the RR pointer; a held request reselects starting
  // just past itself, so it comes last among current requesters.
  assign search_start = (state_q == StHold) ? sel_next : rr_ptr_q;

  // Rotate a doubled copy so bit i is VC (search_start + i) mod NUM_VC.
  assign vld_rot = {vc_valid, vc_valid} >> search_start;

  always_comb begin
    found     = 1'b0;
    found_off = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!found && vld_rot[i]) begin
        found     = 1'b1;
        found_off = VC_INDEX_WIDTH'(i);
      end
    end
    found_sum = {1'b0, search_start} + {1'b0, found_off};
    if (found_sum >= NumVcExt) begin
      found_sum = found_sum - NumVcExt;
    end
    found_idx = found_sum[VC_INDEX_WIDTH-1:0];
  end

  always_comb begin
    found_req  = '0;
    held_valid = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (found_idx == VC_INDEX_WIDTH'(v)) begin
        found_req = req_in[v*NUM_PORT +: NUM_PORT];
      end
      if (sel_vc_q == VC_INDEX_WIDTH'(v)) begin
        held_valid = vc_valid[v];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    wait_d      = wait_q;
    req_valid_d = req_valid_q;
    req_out_d   = req_out_q;
    sel_vc_d    = sel_vc_q;
    timeout_d   = 1'b0;
    load        = 1'b0;
    release_req = 1'b0;

    unique case (state_q)
      StIdle: begin
        load        = found;
        release_req = !found;
      end
      StHold: begin
        if (grant) begin
          rr_ptr_d    = sel_next;
          load        = found;
          release_req = !found;
        end else if (!held_valid) begin
          // Squash: pointer untouched so this VC keeps priority on return.
          release_req = 1'b1;
        end else if (TimeoutEn && (wait_q == WaitLim)) begin
          rr_ptr_d    = sel_next;
          timeout_d   = 1'b1;
          load        = found;
          release_req = !found;
        end else if (wait_q != WaitLim) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: release_req = 1'b1;
    endcase

    if (load) begin
      state_d     = StHold;
      req_valid_d = 1'b1;
      req_out_d   = found_req;
      sel_vc_d    = found_idx;
      wait_d      = '0;
    end
    if (release_req) begin
      state_d     = StIdle;
      req_valid_d = 1'b0;
      req_out_d   = '0;
      sel_vc_d    = '0;
      wait_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      wait_q      <= '0;
      req_valid_q <= 1'b0;
      req_out_q   <= '0;
      sel_vc_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_q      <= wait_d;
      req_valid_q <= req_valid_d;
      req_out_q   <= req_out_d;
      sel_vc_q    <= sel_vc_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_out   = req_out_q;
  assign sel_vc    = sel_vc_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/vc_req_sel_rr.md
Name: vc_req_sel_rr

Overview:
Per-input-port virtual-channel (VC) request selector. Each of NUM_VC VCs offers a one-hot output-port request vector. The block picks one requesting VC round-robin and presents its request to the switch allocator as a registered, stable request. It holds that request until granted, squashed, or timed out, then advances.

Parameters:
NUM_VC, 5, number of VCs per input port (2..16)
NUM_PORT, 5, width of each output-port request vector
VC_INDEX_WIDTH, 3, width of VC index; must satisfy 2^VC_INDEX_WIDTH >= NUM_VC
WAIT_LIMIT, 15, cycles a held request may wait ungranted before rotation; 0 disables timeout
WAIT_W, 4, width of wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  synchronous, active-high reset
vc_valid  input  NUM_VC  bit v set: VC v has a head flit requesting
req_in  input  NUM_VC*NUM_PORT  request vector of VC v in bits [v*NUM_PORT +: NUM_PORT]
grant  input  1  allocator accepted the presented request this cycle
req_valid  output  1  req_out/sel_vc carry a live request
req_out  output  NUM_PORT  registered request vector of selected VC
sel_vc  output  VC_INDEX_WIDTH  index of selected VC
timeout  output  1  one-cycle pulse: held request rotated out by timeout

Behaviour:
- Reset:
  - Sync, active-high: reset sampled high at an edge forces req_valid=0, req_out=0, sel_vc=0, timeout=0.
  - Same edge also sets rr_ptr=0, wait_cnt=0, state=IDLE.
  - Reset mid-HOLD drops the request with no grant side effects.
- State IDLE:
  - Search vc_valid starting at rr_ptr, ascending, wrapping modulo NUM_VC.
  - First set bit v: next edge registers req_out=req_in[v], sel_vc=v, req_valid=1, wait_cnt=0, state=HOLD. Latency: vc_valid to req_valid is 1 cycle.
  - No bit set: stay IDLE, outputs 0.
- State HOLD:
  - req_out and sel_vc stay frozen; req_in changes on the held VC are ignored.
  - grant=1 with req_valid=1:
    - rr_ptr <= (sel_vc+1) mod NUM_VC.
    - In the same cycle, search from (sel_vc+1) with the current vc_valid. If a VC is found, load it at the next edge (back-to-back, no bubble) and stay in HOLD; otherwise go to IDLE with req_valid=0.
    - The granted VC is eligible again only after the others in RR order.
  - Squash, vc_valid[sel_vc]=0 and grant=0:
    - Next edge: req_valid=0, state=IDLE.
    - rr_ptr unchanged, so the same VC regains priority when it returns.
  - Timeout, WAIT_LIMIT>0 and grant=0 and wait_cnt==WAIT_LIMIT:
    - rr_ptr <= sel_vc+1 mod NUM_VC; timeout=1 for one cycle.
    - Reselect as in the grant path, so the same VC is chosen again only if it is the sole requester.
  - Otherwise: wait_cnt increments, saturating at WAIT_LIMIT.
- Priority of simultaneous events: grant > squash > timeout.
- Width and index rules:
  - Indices >= NUM_VC never selected; vc_valid bits are masked to NUM_VC.
  - Pointer wrap uses explicit compare (NUM_VC need not be a power of 2).
- grant while req_valid=0 is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset 2 cycles with vc_valid=5'b11111 -> req_valid=0, req_out=0, sel_vc=0 throughout. First post-reset edge -> sel_vc=0, req_out=req_in[0].
- Round-robin: vc_valid=5'b10110, grant=1 every cycle -> sel_vc sequence 1,2,4,1,2,4…, req_valid continuously 1.
- Hold stability: select VC3 with req_in[3]=5'b00100, change req_in[3] to 5'b01000 with grant=0 -> req_out stays 5'b00100 until grant.
- Squash: hold VC2, drop vc_valid[2] -> req_valid=0 next cycle. Reassert vc_valid=5'b00101 -> sel_vc=2 selected before 0.
- Timeout: WAIT_LIMIT=3, vc_valid=5'b00011, grant=0 -> VC0 held 4 cycles, then timeout pulses once and sel_vc=1. With only VC0 valid -> VC0 reselected with timeout pulse.
- Wrap and priority: NUM_VC=5, hold VC4, assert grant and drop vc_valid[4] in the same cycle -> treated as grant, rr_ptr=0, next selection is the lowest valid index.
